// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaled period counter, double-buffered duty per channel.
// Optional center-aligned (up/down) counting is enabled by defining PWM_CENTER_ALIGN_EN.
module pwm_multi_gen #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 8
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               en,
  input  logic [PRESC_W-1:0]                                 presc,
  input  logic [WIDTH-1:0]                                   period,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                                               center,
`endif
  input  logic                                               wr_valid,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
  input  logic [WIDTH-1:0]                                   wr_duty,
  output logic                                               wr_ready,
  output logic [CHANNELS-1:0]                                pending,
  output logic                                               period_done,
  output logic [CHANNELS-1:0]                                pwm_out
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PRESC_W-1:0]             presc_cnt_q, presc_cnt_d, presc_act_q, presc_act_d;
  logic [WIDTH-1:0]               cnt_q, cnt_d, period_act_q, period_act_d;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_act_q, duty_act_d, duty_stg_q, duty_stg_d;
  logic [CHANNELS-1:0]            pending_q, pending_d, pwm_q, pwm_d;
  logic                           done_q, done_d;
  logic                           tick, at_top, bnd, load, accept, chan_ok;
  logic [(1<<CW)-1:0]             pend_pad;
`ifdef PWM_CENTER_ALIGN_EN
  logic                           center_act_q, center_act_d, down_q, down_d, folding;
`endif

  if (CHANNELS == (1 << CW)) begin : g_full
    assign chan_ok = 1'b1;
  end else begin : g_part
    assign chan_ok = (int'(wr_chan) < CHANNELS);
  end

  // Pad pending to the full index range so an out-of-range channel reads a defined bit.
  always_comb begin
    pend_pad = '0;
    pend_pad[CHANNELS-1:0] = pending_q;
  end

  assign wr_ready = chan_ok & ~pend_pad[wr_chan];
  assign accept   = wr_valid & wr_ready;

  always_comb begin
    tick   = (presc_cnt_q == presc_act_q);
    at_top = (cnt_q == period_act_q);
`ifdef PWM_CENTER_ALIGN_EN
    folding = center_act_q && (period_act_q != '0);
    bnd     = tick && (folding ? (down_q && cnt_q == WIDTH'(1)) : at_top);
`else
    bnd     = tick && at_top;
`endif
    // Disabled cycles behave as a permanent boundary so staged values load at once.
    load = !en || bnd;

    presc_cnt_d  = tick ? '0 : presc_cnt_q + 1'b1;
    cnt_d        = cnt_q;
    presc_act_d  = presc_act_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    duty_stg_d   = duty_stg_q;
    pending_d    = pending_q;
`ifdef PWM_CENTER_ALIGN_EN
    center_act_d = center_act_q;
    down_d       = down_q;
`endif

    if (tick) begin
      if (bnd) begin
        cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
        down_d = 1'b0;
      end else if (down_q) begin
        cnt_d = cnt_q - 1'b1;
      end else if (folding && at_top) begin
        cnt_d  = cnt_q - 1'b1;
        down_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (!en) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
`ifdef PWM_CENTER_ALIGN_EN
      down_d      = 1'b0;
`endif
    end

    if (load) begin
      presc_act_d  = presc;
      period_act_d = period;
`ifdef PWM_CENTER_ALIGN_EN
      center_act_d = center;
`endif
    end

    // Clear before set: a write accepted on a boundary waits for the next one.
    for (int i = 0; i < CHANNELS; i++) begin
      if (load && pending_q[i]) begin
        duty_act_d[i] = duty_stg_q[i];
        pending_d[i]  = 1'b0;
      end
      if (accept && wr_chan == CW'(i)) begin
        duty_stg_d[i] = wr_duty;
        pending_d[i]  = 1'b1;
      end
      pwm_d[i] = en && (cnt_q < duty_act_q[i]);
    end

    done_d = en && bnd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q  <= '0;
      presc_act_q  <= '0;
      cnt_q        <= '0;
      period_act_q <= '0;
      duty_act_q   <= '0;
      duty_stg_q   <= '0;
      pending_q    <= '0;
      pwm_q        <= '0;
      done_q       <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      center_act_q <= 1'b0;
      down_q       <= 1'b0;
`endif
    end else begin
      presc_cnt_q  <= presc_cnt_d;
      presc_act_q  <= presc_act_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      duty_stg_q   <= duty_stg_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      done_q       <= done_d;
`ifdef PWM_CENTER_ALIGN_EN
      center_act_q <= center_act_d;
      down_q       <= down_d;
`endif
    end
  end

  assign pending     = pending_q;
  assign period_done = done_q;
  assign pwm_out     = pwm_q;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: per-cycle expected pwm_out/period_done queued and popped.
module tb_pwm_multi_gen;
  logic       clk, rst, en, wr_valid, wr_ready, period_done, center;
  logic [7:0] presc, period, wr_duty;
  logic [1:0] wr_chan;
  logic [3:0] pending, pwm_out;

  typedef struct {
    logic [3:0] pwm;
    logic       done;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  pwm_multi_gen #(.CHANNELS(4), .WIDTH(8), .PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .presc(presc), .period(period),
`ifdef PWM_CENTER_ALIGN_EN
    .center(center),
`endif
    .wr_valid(wr_valid), .wr_chan(wr_chan), .wr_duty(wr_duty), .wr_ready(wr_ready),
    .pending(pending), .period_done(period_done), .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] pwm, input logic done);
    exp_t e;
    e.pwm  = pwm;
    e.done = done;
    q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_pwm"}, {28'd0, pwm_out}, {28'd0, e.pwm});
      chk({tag, "_done"}, {31'd0, period_done}, {31'd0, e.done});
    end
  endtask

  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1;
    wr_chan  = 2'(ch);
    wr_duty  = 8'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; wr_valid = 1'b0; wr_chan = '0; wr_duty = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int seq [8];
    center = 1'b0;
    presc  = 8'd0;
    period = 8'd9;

    // --- reset state, then duty 3 of period 10 on ch0
    do_reset();
    chk("rst_pwm", {28'd0, pwm_out}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_done", {31'd0, period_done}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
    wr(0, 3); cyc(); wr_valid = 1'b0;
    chk("t1_e0_done", {31'd0, period_done}, 32'd1);
    chk("t1_e0_pend", {28'd0, pending}, 32'h1);
    for (int k = 1; k <= 30; k++)
      push((k >= 11 && (k - 11) % 10 < 3) ? 4'b0001 : 4'b0000, (k % 10) == 0);
    for (int k = 1; k <= 30; k++) begin
      cyc();
      pop_check("t1");
      if (k == 9)  chk("t1_pend_held", {28'd0, pending}, 32'h1);
      if (k == 10) chk("t1_pend_clr", {28'd0, pending}, 32'h0);
    end

    // --- prescaled: duty > period is 100%, then duty 0
    presc = 8'd3; period = 8'd4;
    do_reset();
    wr(1, 5); cyc(); wr_valid = 1'b0;
    for (int k = 1; k <= 60; k++)
      push((k >= 21 && k <= 40) ? 4'b0010 : 4'b0000, k == 20 || k == 40 || k == 60);
    for (int k = 1; k <= 60; k++) begin
      if (k == 25) begin
        wr(1, 0);
        #1 chk("t2_ready", {31'd0, wr_ready}, 32'd1);
      end
      cyc();
      if (k == 25) wr_valid = 1'b0;
      pop_check("t2");
      if (k == 25) chk("t2_pend_set", {28'd0, pending}, 32'h2);
      if (k == 40) chk("t2_pend_clr", {28'd0, pending}, 32'h0);
    end

    // --- stall on pending channel, other channel proceeds
    presc = 8'd0; period = 8'd9;
    do_reset();
    wr(2, 2); cyc(); wr_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      logic [3:0] p;
      p = '0;
      p[2] = (k >= 11) && ((k - 11) % 10 < ((k >= 21) ? 6 : 2));
      p[3] = (k >= 11) && ((k - 11) % 10 < 4);
      push(p, (k % 10) == 0);
    end
    for (int k = 1; k <= 30; k++) begin
      if (k == 1)  wr(3, 4);
      if (k == 2)  wr(2, 6);
      if (k == 12) wr_valid = 1'b0;
      #1;
      if (k == 1)            chk("t3_ready_ch3", {31'd0, wr_ready}, 32'd1);
      if (k >= 2 && k <= 10) chk("t3_stall", {31'd0, wr_ready}, 32'd0);
      if (k == 11)           chk("t3_ready_after", {31'd0, wr_ready}, 32'd1);
      cyc();
      pop_check("t3");
      if (k == 1)  chk("t3_pend_e1", {28'd0, pending}, 32'hC);
      if (k == 10) chk("t3_pend_e10", {28'd0, pending}, 32'h0);
      if (k == 11) chk("t3_pend_e11", {28'd0, pending}, 32'h4);
      if (k == 20) chk("t3_pend_e20", {28'd0, pending}, 32'h0);
    end

    // --- disabled: immediate load, then counting from 0 on enable
    presc = 8'd0; period = 8'd15;
    do_reset();
    en = 1'b0;
    wr(0, 7); cyc(); wr_valid = 1'b0;
    chk("t4_pend_e0", {28'd0, pending}, 32'h1);
    chk("t4_pwm_e0", {28'd0, pwm_out}, 32'h0);
    for (int k = 1; k <= 36; k++)
      push((k >= 4 && (k - 4) % 16 < 7) ? 4'b0001 : 4'b0000,
           k >= 4 && (k - 4) % 16 == 15);
    for (int k = 1; k <= 36; k++) begin
      if (k == 4) en = 1'b1;
      cyc();
      pop_check("t4");
      if (k == 1) chk("t4_pend_clr", {28'd0, pending}, 32'h0);
    end

    // --- reset mid-period discards active and staged duties
    presc = 8'd0; period = 8'd9;
    do_reset();
    wr(0, 5); cyc(); wr_valid = 1'b0;
    for (int k = 1; k <= 13; k++)
      push((k >= 11 && (k - 11) % 10 < 5) ? 4'b0001 : 4'b0000, (k % 10) == 0);
    for (int k = 1; k <= 13; k++) begin
      if (k == 12) wr(1, 3);
      cyc();
      if (k == 12) wr_valid = 1'b0;
      pop_check("t5_pre");
    end
    chk("t5_pend_pre", {28'd0, pending}, 32'h2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_rst_pwm", {28'd0, pwm_out}, 32'h0);
    chk("t5_rst_pend", {28'd0, pending}, 32'h0);
    chk("t5_rst_done", {31'd0, period_done}, 32'd0);
    for (int k = 1; k <= 25; k++) push(4'b0000, ((k - 1) % 10) == 0);
    for (int k = 1; k <= 25; k++) begin
      cyc();
      pop_check("t5_post");
      if (k == 12) chk("t5_pend_post", {28'd0, pending}, 32'h0);
    end

`ifdef PWM_CENTER_ALIGN_EN
    // --- center-aligned: 0,1,2,3,4,3,2,1 per 8-clock period
    seq = '{0, 1, 2, 3, 4, 3, 2, 1};
    center = 1'b1; presc = 8'd0; period = 8'd4;
    do_reset();
    wr(0, 2); cyc(); wr_valid = 1'b0;
    for (int k = 1; k <= 24; k++)
      push((k >= 9 && seq[(k - 9) % 8] < 2) ? 4'b0001 : 4'b0000, (k % 8) == 0);
    for (int k = 1; k <= 24; k++) begin
      cyc();
      pop_check("t6");
    end
    center = 1'b0;
`else
    seq = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    chk("sb_drained", q.size(), 32'd0 + seq[0]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
